eth_mac_stats_counters: RTL

//  Multi-port statistics block for the 10G MAC+FIFO wrappers. Counts the status

---
 rtl/eth_mac_stats_pkg.sv | 23 ++
 rtl/eth_mac_stats_cnt.sv | 34 +++
 rtl/eth_mac_stats_counters.sv | 100 ++++++++++
 3 files changed

// File: rtl/eth_mac_stats_pkg.sv
// Shared constants for the Ethernet MAC statistics block: event indices,
// the address layout and a helper that builds a read address.
package eth_mac_stats_pkg;

  localparam int EVENTS     = 9;
  localparam int EV_FIELD_W = 4;

  localparam int EV_TX_ERROR_UNDERFLOW = 0;
  localparam int EV_TX_FIFO_OVERFLOW   = 1;
  localparam int EV_TX_FIFO_BAD_FRAME  = 2;
  localparam int EV_TX_FIFO_GOOD_FRAME = 3;
  localparam int EV_RX_ERROR_BAD_FRAME = 4;
  localparam int EV_RX_ERROR_BAD_FCS   = 5;
  localparam int EV_RX_FIFO_OVERFLOW   = 6;
  localparam int EV_RX_FIFO_BAD_FRAME  = 7;
  localparam int EV_RX_FIFO_GOOD_FRAME = 8;

  // Read address is {port, event[3:0]}; callers truncate to ADDR_WIDTH.
  function automatic logic [31:0] stat_addr(input int port, input int ev);
    return 32'((port << EV_FIELD_W) | (ev & ((1 << EV_FIELD_W) - 1)));
  endfunction

endpackage

// File: rtl/eth_mac_stats_cnt.sv
// One saturating event counter with per-counter clear, global clear and a
// sticky saturation flag that only a global clear or reset removes.
module eth_mac_stats_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic                 clr_all,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 sat
);

  localparam logic [CNT_WIDTH-1:0] MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] MAX_M1 = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      // An event coinciding with a clear is kept, not lost.
      value <= inc ? ONE : '0;
    end else if (inc && value != MAX) begin
      value <= value + ONE;
      if (value == MAX_M1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_mac_stats_counters.sv
// Per-port MAC/FIFO event statistics with a registered read port and
// clear-on-read. Optional snapshot shadow bank under `STATS_SNAPSHOT_EN.
module eth_mac_stats_counters
  import eth_mac_stats_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(PORTS) + EV_FIELD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS*EVENTS-1:0]   stat_event,
  input  logic                      clear_all,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_clear,
  output logic [CNT_WIDTH-1:0]      rd_data,
  output logic                      rd_valid,
  input  logic                      snapshot_req,
  output logic [PORTS-1:0]          sat_flag
);

  localparam int NCNT = PORTS * EVENTS;

  logic [CNT_WIDTH-1:0] live   [NCNT];
  logic [CNT_WIDTH-1:0] rd_src [NCNT];
  logic [NCNT-1:0]      sat_bits;
  logic [NCNT-1:0]      clr_sel;
  logic [CNT_WIDTH-1:0] rd_mux;
  logic                 rd_hit;
  int                   rd_port;
  int                   rd_ev;
  int                   rd_idx;

  always_comb begin
    rd_port = int'(rd_addr >> EV_FIELD_W);
    rd_ev   = int'(rd_addr[EV_FIELD_W-1:0]);
    rd_hit  = (rd_ev < EVENTS) && (rd_port < PORTS);
    rd_idx  = rd_port * EVENTS + rd_ev;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    clr_sel = '0;
    if (rd_en && rd_clear && rd_hit) clr_sel[rd_idx] = 1'b1;
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    eth_mac_stats_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (stat_event[i]),
      .clr     (clr_sel[i]),
      .clr_all (clear_all),
      .value   (live[i]),
      .sat     (sat_bits[i])
    );
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_sat
    assign sat_flag[p] = |sat_bits[p*EVENTS +: EVENTS];
  end

`ifdef STATS_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shadow [NCNT];

  // NOTE: the shadow bank is explicitly reset because reads expose it directly;
  // a pure storage array without that requirement would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) shadow[i] <= '0;
    end else if (snapshot_req) begin
      for (int i = 0; i < NCNT; i++) shadow[i] <= live[i];
    end
  end

  assign rd_src = shadow;
`else
  logic unused_snapshot_req;
  assign unused_snapshot_req = snapshot_req;
  assign rd_src = live;
`endif

  always_comb begin
    rd_mux = '0;
    if (rd_hit) rd_mux = rd_src[rd_idx];
  end

  // Read data reflects the counter before this cycle's update or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
